status_frame_parser: RTL and testbench
======================================

STATUS_FRAME_PARSER -- requirements
Module: status_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter BAUDRATE, default 2_000_000, UART bit rate used to derive the inter-byte timeout.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-006 SHALL have port rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 SHALL have port frame_valid  output  1  one-cycle pulse: a good frame has been decoded.
REQ-008 SHALL have ports motor_id and control_mode  output  8 each  payload bytes 0 and 1.
REQ-009 SHALL have ports encoder0_position, encoder1_position, setpoint, duty and displacement  output  24 signed each  fields from payload bytes 2-16, MSB first.
REQ-010 SHALL have ports current  output  16 signed  and  neopxl_color  output  24  fields from payload bytes 17-18 and 19-21.
REQ-011 SHALL have ports crc_error and timeout_error  output  1 each  one-cycle error pulses.
REQ-012 SHALL have ports frames_ok and frames_bad  output  32 each  statistics counters.

Function
REQ-013 SHALL implement states HUNT, PAYLOAD and CHECK.
REQ-014 SHALL keep, in HUNT, a 4-byte shift register of the last accepted bytes; the rx_valid byte that completes 1C EB 00 DA moves the FSM to PAYLOAD on the next edge.
REQ-015 SHALL clear the shift register and the payload index, and load CRC=16'hFFFF, when entering PAYLOAD.
REQ-016 SHALL, in PAYLOAD, store each rx_valid byte at index 0..23, and update the CRC incrementally for indices 0..21 with polynomial x^16+x^15+x^2+1, 8-bit input, first serial bit D[7].
REQ-017 SHALL not re-detect the magic inside the payload; a magic pattern in payload bytes is treated as data.
REQ-018 SHALL move to CHECK on the edge accepting index 23, with a good frame defined as CRC[15:8]==byte22 and CRC[7:0]==byte23.
REQ-019 SHALL, one edge after entering CHECK, on a good frame update all field outputs, pulse frame_valid and increment frames_ok, so that frame_valid is high in cycle N+2 when byte 23 arrives in cycle N.
REQ-020 SHALL, on a bad frame, pulse crc_error in the same cycle position, increment frames_bad, and leave field outputs unchanged.
REQ-021 SHALL return from CHECK to HUNT; a byte with rx_valid=1 during CHECK is shifted into the cleared HUNT register and is not lost.
REQ-022 SHALL, in PAYLOAD, count clocks since the last accepted byte; reaching TIMEOUT=40*CLK_FREQ_HZ/BAUDRATE (4 byte times) pulses timeout_error, increments frames_bad and returns to HUNT with the shift register cleared.
REQ-023 SHALL reset the gap counter on every accepted byte, and the timer SHALL be inactive in HUNT and CHECK.
REQ-024 SHALL let frames_ok and frames_bad wrap from 32'hFFFFFFFF to 0.
REQ-025 SHALL hold field outputs at the last good frame between frames.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, force state HUNT, clear the shift register, index, gap counter and both counters, set all field outputs to 0 and deassert all pulses.
REQ-027 SHALL discard a frame when reset occurs mid-frame, without pulsing any error or valid.

Configuration
REQ-028 SHALL, with STATUS_PARSER_STATS_EN defined, implement frames_ok and frames_bad as specified.
REQ-029 SHALL, without STATUS_PARSER_STATS_EN, tie frames_ok and frames_bad to 0 with no counter registers; all other behaviour is unchanged.

Verification
REQ-030 Good frame, id=0x03, mode=0x02, enc0=0x000100, current=0xFF38, correct CRC -> frame_valid in cycle N+2, motor_id=0x03, encoder0_position=256, current=-200, frames_ok=1.
REQ-031 Same frame with byte 23 XOR 0x01 -> crc_error pulse, frame_valid stays 0, outputs retain previous values, frames_bad=1.
REQ-032 Garbage bytes 0x1C,0x1C,0xEB,0x00,0xDA followed by a good frame -> sync on the last four bytes and frame_valid=1.
REQ-033 Magic plus 10 payload bytes, then a gap of TIMEOUT cycles -> timeout_error pulse, HUNT; a subsequent good frame decodes.
REQ-034 Back-to-back good frames where the first magic byte arrives in the CHECK cycle -> both frames decoded, frames_ok=2.
REQ-035 Reset asserted after payload byte 12 -> no pulses, counters 0, outputs 0; the next good frame decodes.

Source files
------------

// File: rtl/status_frame_parser.sv
// status_frame_parser: decodes UART status frames (magic 1C EB 00 DA, 24-byte payload, CRC-16 poly 0x8005).
// Optional macro STATUS_PARSER_STATS_EN builds the frames_ok/frames_bad statistics counters.
module status_frame_parser #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUDRATE    = 2_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               frame_valid,
   output logic [7:0]         motor_id,
   output logic [7:0]         control_mode,
   output logic signed [23:0] encoder0_position,
   output logic signed [23:0] encoder1_position,
   output logic signed [23:0] setpoint,
   output logic signed [23:0] duty,
   output logic signed [23:0] displacement,
   output logic signed [15:0] current,
   output logic [23:0]        neopxl_color,
   output logic               crc_error,
   output logic               timeout_error,
   output logic [31:0]        frames_ok,
   output logic [31:0]        frames_bad
);

   localparam logic [63:0] TIMEOUT_W  = (64'd40 * 64'(CLK_FREQ_HZ)) / 64'(BAUDRATE);
   localparam logic [31:0] TIMEOUT_M1 = TIMEOUT_W[31:0] - 32'd1;
   localparam logic [31:0] MAGIC      = 32'h1CEB_00DA;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] shift_r;
   logic [31:0] hunt_word_s;
   logic [4:0]  idx_r;
   logic [15:0] crc_r;
   logic [7:0]  pay_r [0:23];
   logic [31:0] gap_r;
   logic        magic_hit_s;
   logic        timeout_s;
   logic        frame_good_s;
   logic        frame_bad_s;

   // One byte of CRC-16, polynomial 0x8005, D[7] shifted in first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return c;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= HUNT;
      else       state_r <= state_nxt_s;
   end

   // Next-state logic plus the sync, timeout and CRC verdict strobes.
   always_comb begin
      state_nxt_s  = state_r;
      hunt_word_s  = {shift_r[23:0], rx_data};
      magic_hit_s  = 1'b0;
      timeout_s    = 1'b0;
      frame_good_s = 1'b0;
      frame_bad_s  = 1'b0;
      case (state_r)
         HUNT: begin
            if (rx_valid && (hunt_word_s == MAGIC)) begin
               magic_hit_s = 1'b1;
               state_nxt_s = PAYLOAD;
            end else begin
               state_nxt_s = HUNT;
            end
         end
         PAYLOAD: begin
            if (rx_valid) begin
               if (idx_r == 5'd23) state_nxt_s = CHECK;
               else                state_nxt_s = PAYLOAD;
            end else if (gap_r >= TIMEOUT_M1) begin
               timeout_s   = 1'b1;
               state_nxt_s = HUNT;
            end else begin
               state_nxt_s = PAYLOAD;
            end
         end
         CHECK: begin
            frame_good_s = (crc_r == {pay_r[22], pay_r[23]});
            frame_bad_s  = ~frame_good_s;
            state_nxt_s  = HUNT;
         end
         default: state_nxt_s = HUNT;
      endcase
   end

   // Byte capture, CRC accumulation, gap timer, field outputs and pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r           <= 32'd0;
         idx_r             <= 5'd0;
         crc_r             <= 16'hFFFF;
         gap_r             <= 32'd0;
         frame_valid       <= 1'b0;
         crc_error         <= 1'b0;
         timeout_error     <= 1'b0;
         motor_id          <= 8'd0;
         control_mode      <= 8'd0;
         encoder0_position <= 24'sd0;
         encoder1_position <= 24'sd0;
         setpoint          <= 24'sd0;
         duty              <= 24'sd0;
         displacement      <= 24'sd0;
         current           <= 16'sd0;
         neopxl_color      <= 24'd0;
         for (int i = 0; i < 24; i++) pay_r[i] <= 8'd0;
      end else begin
         frame_valid   <= 1'b0;
         crc_error     <= 1'b0;
         timeout_error <= 1'b0;
         case (state_r)
            HUNT: begin
               if (magic_hit_s) begin
                  shift_r <= 32'd0;
                  idx_r   <= 5'd0;
                  crc_r   <= 16'hFFFF;
                  gap_r   <= 32'd0;
               end else if (rx_valid) begin
                  shift_r <= hunt_word_s;
               end
            end
            PAYLOAD: begin
               if (rx_valid) begin
                  pay_r[idx_r] <= rx_data;
                  if (idx_r < 5'd22) crc_r <= crc16_byte(crc_r, rx_data);
                  idx_r <= idx_r + 5'd1;
                  gap_r <= 32'd0;
               end else if (timeout_s) begin
                  timeout_error <= 1'b1;
                  shift_r       <= 32'd0;
                  gap_r         <= 32'd0;
               end else begin
                  gap_r <= gap_r + 32'd1;
               end
            end
            CHECK: begin
               if (frame_good_s) begin
                  frame_valid       <= 1'b1;
                  motor_id          <= pay_r[0];
                  control_mode      <= pay_r[1];
                  encoder0_position <= {pay_r[2], pay_r[3], pay_r[4]};
                  encoder1_position <= {pay_r[5], pay_r[6], pay_r[7]};
                  setpoint          <= {pay_r[8], pay_r[9], pay_r[10]};
                  duty              <= {pay_r[11], pay_r[12], pay_r[13]};
                  displacement      <= {pay_r[14], pay_r[15], pay_r[16]};
                  current           <= {pay_r[17], pay_r[18]};
                  neopxl_color      <= {pay_r[19], pay_r[20], pay_r[21]};
               end else begin
                  crc_error <= 1'b1;
               end
               // A byte arriving here starts the next hunt rather than being dropped.
               shift_r <= rx_valid ? {24'd0, rx_data} : 32'd0;
            end
            default: shift_r <= 32'd0;
         endcase
      end
   end

`ifdef STATUS_PARSER_STATS_EN
   logic [31:0] ok_cnt_r;
   logic [31:0] bad_cnt_r;

   // Good/bad frame statistics, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         ok_cnt_r  <= 32'd0;
         bad_cnt_r <= 32'd0;
      end else begin
         if (frame_good_s)              ok_cnt_r  <= ok_cnt_r + 32'd1;
         if (frame_bad_s || timeout_s)  bad_cnt_r <= bad_cnt_r + 32'd1;
      end
   end

   assign frames_ok  = ok_cnt_r;
   assign frames_bad = bad_cnt_r;
`else
   assign frames_ok  = 32'd0;
   assign frames_bad = 32'd0;
`endif

endmodule

// File: tb/tb_status_frame_parser.sv
// tb_status_frame_parser: directed self-checking bench for status_frame_parser.
// Counter expectations follow STATUS_PARSER_STATS_EN (zero when the macro is undefined).
module tb_status_frame_parser;

   localparam int TIMEOUT = 40 * 50_000_000 / 2_000_000;
`ifdef STATUS_PARSER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               clk;
   logic               reset;
   logic               rx_valid;
   logic [7:0]         rx_data;
   logic               frame_valid;
   logic [7:0]         motor_id;
   logic [7:0]         control_mode;
   logic signed [23:0] encoder0_position;
   logic signed [23:0] encoder1_position;
   logic signed [23:0] setpoint;
   logic signed [23:0] duty;
   logic signed [23:0] displacement;
   logic signed [15:0] current;
   logic [23:0]        neopxl_color;
   logic               crc_error;
   logic               timeout_error;
   logic [31:0]        frames_ok;
   logic [31:0]        frames_bad;

   status_frame_parser dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .frame_valid(frame_valid), .motor_id(motor_id), .control_mode(control_mode),
      .encoder0_position(encoder0_position), .encoder1_position(encoder1_position),
      .setpoint(setpoint), .duty(duty), .displacement(displacement),
      .current(current), .neopxl_color(neopxl_color),
      .crc_error(crc_error), .timeout_error(timeout_error),
      .frames_ok(frames_ok), .frames_bad(frames_bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int exp_ok       = 0;
   int exp_bad      = 0;
   int fv_seen      = 0;
   int ce_seen      = 0;
   int to_seen      = 0;
   logic [7:0] fr [0:23];

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (frame_valid   === 1'b1) fv_seen++;
      if (crc_error     === 1'b1) ce_seen++;
      if (timeout_error === 1'b1) to_seen++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before 1000000");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
      return c;
   endfunction

   task automatic make_frame(input logic [7:0] id, input logic [7:0] mode,
                             input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] sp, input logic [23:0] du,
                             input logic [23:0] di, input logic [15:0] cur,
                             input logic [23:0] col);
      logic [15:0] c;
      fr[0] = id;  fr[1] = mode;
      {fr[2],  fr[3],  fr[4]}  = e0;
      {fr[5],  fr[6],  fr[7]}  = e1;
      {fr[8],  fr[9],  fr[10]} = sp;
      {fr[11], fr[12], fr[13]} = du;
      {fr[14], fr[15], fr[16]} = di;
      {fr[17], fr[18]}         = cur;
      {fr[19], fr[20], fr[21]} = col;
      c = 16'hFFFF;
      for (int i = 0; i < 22; i++) c = crc_ref(c, fr[i]);
      fr[22] = c[15:8];
      fr[23] = c[7:0];
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_magic();
      send_byte(8'h1C); send_byte(8'hEB); send_byte(8'h00); send_byte(8'hDA);
   endtask

   task automatic send_payload(input int n);
      for (int i = 0; i < n; i++) send_byte(fr[i]);
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_fv: got %0b want 0", frame_valid); end
      tests_run++; if (crc_error !== 1'b0 || timeout_error !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0b%0b want 00", crc_error, timeout_error); end
      tests_run++; if (motor_id !== 8'h00 || encoder0_position !== 24'sd0 || current !== 16'sd0) begin tests_failed++; $display("FAIL rst_fields: got %0h/%0h/%0h want 0/0/0", motor_id, encoder0_position, current); end
      tests_run++; if (frames_ok !== 32'd0 || frames_bad !== 32'd0) begin tests_failed++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", frames_ok, frames_bad); end
   endtask

   task automatic test_good_frame();
      make_frame(8'h03, 8'h02, 24'h000100, 24'h123456, 24'hFFFFFF, 24'h7FFFFF,
                 24'h800000, 16'hFF38, 24'hA5B6C7);
      send_magic();
      send_payload(24);
      tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL good_fv_n1: got %0b want 0", frame_valid); end
      @(negedge clk);
      exp_ok++;
      tests_run++; if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL good_fv_n2: got %0b want 1", frame_valid); end
      tests_run++; if (motor_id !== 8'h03 || control_mode !== 8'h02) begin tests_failed++; $display("FAIL good_id_mode: got %0h/%0h want 3/2", motor_id, control_mode); end
      tests_run++; if (encoder0_position !== 24'sd256) begin tests_failed++; $display("FAIL good_enc0: got %0d want 256", encoder0_position); end
      tests_run++; if (current !== -16'sd200) begin tests_failed++; $display("FAIL good_current: got %0d want -200", current); end
      tests_run++; if (encoder1_position !== 24'sh123456 || setpoint !== -24'sd1 || duty !== 24'sd8388607) begin tests_failed++; $display("FAIL good_mid: got %0h/%0d/%0d want 123456/-1/8388607", encoder1_position, setpoint, duty); end
      tests_run++; if (displacement !== -24'sd8388608 || neopxl_color !== 24'hA5B6C7) begin tests_failed++; $display("FAIL good_tail: got %0d/%0h want -8388608/a5b6c7", displacement, neopxl_color); end
      @(negedge clk);
      tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL good_fv_n3: got %0b want 0", frame_valid); end
      tests_run++; if (frames_ok !== (STATS ? 32'(exp_ok) : 32'd0)) begin tests_failed++; $display("FAIL good_frames_ok: got %0d want %0d", frames_ok, STATS ? exp_ok : 0); end
   endtask

   task automatic test_crc_error();
      make_frame(8'h03, 8'h02, 24'h000100, 24'h123456, 24'hFFFFFF, 24'h7FFFFF,
                 24'h800000, 16'hFF38, 24'hA5B6C7);
      fr[0] = 8'h77;
      fr[2] = 8'h44;
      fr[23] = fr[23] ^ 8'h01;
      send_magic();
      send_payload(24);
      @(negedge clk);
      exp_bad++;
      tests_run++; if (crc_error !== 1'b1) begin tests_failed++; $display("FAIL crc_pulse: got %0b want 1", crc_error); end
      tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL crc_fv: got %0b want 0", frame_valid); end
      tests_run++; if (motor_id !== 8'h03 || encoder0_position !== 24'sd256 || current !== -16'sd200) begin tests_failed++; $display("FAIL crc_hold: got %0h/%0d/%0d want 3/256/-200", motor_id, encoder0_position, current); end
      @(negedge clk);
      tests_run++; if (crc_error !== 1'b0) begin tests_failed++; $display("FAIL crc_pulse_end: got %0b want 0", crc_error); end
      tests_run++; if (frames_bad !== (STATS ? 32'(exp_bad) : 32'd0)) begin tests_failed++; $display("FAIL crc_frames_bad: got %0d want %0d", frames_bad, STATS ? exp_bad : 0); end
   endtask

   task automatic test_garbage_sync();
      // Payload carries the magic sequence in bytes 2..5; it must be taken as data.
      make_frame(8'h11, 8'h01, 24'h1CEB00, 24'hDA0102, 24'h000010, 24'h000020,
                 24'h000030, 16'h0040, 24'h010203);
      send_byte(8'h1C); send_byte(8'h1C); send_byte(8'hEB); send_byte(8'h00); send_byte(8'hDA);
      send_payload(24);
      @(negedge clk);
      exp_ok++;
      tests_run++; if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL sync_fv: got %0b want 1", frame_valid); end
      tests_run++; if (motor_id !== 8'h11 || encoder0_position !== 24'sh1CEB00 || encoder1_position !== 24'shDA0102) begin tests_failed++; $display("FAIL sync_fields: got %0h/%0h/%0h want 11/1ceb00/da0102", motor_id, encoder0_position, encoder1_position); end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int k;
      bit found;
      make_frame(8'h22, 8'h05, 24'h000001, 24'h000002, 24'h000003, 24'h000004,
                 24'h000005, 16'h0006, 24'h000007);
      send_magic();
      send_payload(10);
      k = 0; found = 1'b0;
      while (!found && k < TIMEOUT + 20) begin
         @(negedge clk);
         k++;
         if (timeout_error === 1'b1) found = 1'b1;
      end
      exp_bad++;
      tests_run++; if (!found || k != TIMEOUT) begin tests_failed++; $display("FAIL timeout_cycle: got found=%0b at %0d want found=1 at %0d", found, k, TIMEOUT); end
      tests_run++; if (motor_id !== 8'h11) begin tests_failed++; $display("FAIL timeout_hold: got %0h want 11", motor_id); end
      @(negedge clk);
      send_magic();
      send_payload(24);
      @(negedge clk);
      exp_ok++;
      tests_run++; if (frame_valid !== 1'b1 || motor_id !== 8'h22) begin tests_failed++; $display("FAIL timeout_recover: got %0b/%0h want 1/22", frame_valid, motor_id); end
      @(negedge clk);
      tests_run++; if (frames_bad !== (STATS ? 32'(exp_bad) : 32'd0)) begin tests_failed++; $display("FAIL timeout_frames_bad: got %0d want %0d", frames_bad, STATS ? exp_bad : 0); end
   endtask

   task automatic test_back_to_back();
      int fv0;
      int ce0;
      fv0 = fv_seen; ce0 = ce_seen;
      make_frame(8'h31, 8'h01, 24'h000A00, 24'h0, 24'h0, 24'h0, 24'h0, 16'h0001, 24'h0);
      send_magic();
      send_payload(24);
      make_frame(8'h32, 8'h01, 24'h000B00, 24'h0, 24'h0, 24'h0, 24'h0, 16'h0002, 24'h0);
      send_magic();
      send_payload(24);
      repeat (3) @(negedge clk);
      exp_ok += 2;
      tests_run++; if (fv_seen - fv0 != 2 || ce_seen != ce0) begin tests_failed++; $display("FAIL b2b_pulses: got fv=%0d ce=%0d want fv=2 ce=0", fv_seen - fv0, ce_seen - ce0); end
      tests_run++; if (motor_id !== 8'h32 || encoder0_position !== 24'sh000B00) begin tests_failed++; $display("FAIL b2b_fields: got %0h/%0h want 32/b00", motor_id, encoder0_position); end
      tests_run++; if (frames_ok !== (STATS ? 32'(exp_ok) : 32'd0)) begin tests_failed++; $display("FAIL b2b_frames_ok: got %0d want %0d", frames_ok, STATS ? exp_ok : 0); end
   endtask

   task automatic test_reset_midframe();
      int fv0;
      int ce0;
      int to0;
      make_frame(8'h41, 8'h03, 24'h000C00, 24'h0, 24'h0, 24'h0, 24'h0, 16'hFFFE, 24'h0);
      send_magic();
      send_payload(13);
      fv0 = fv_seen; ce0 = ce_seen; to0 = to_seen;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      exp_ok = 0; exp_bad = 0;
      tests_run++; if (fv_seen != fv0 || ce_seen != ce0 || to_seen != to0) begin tests_failed++; $display("FAIL midrst_pulses: got %0d/%0d/%0d want 0/0/0", fv_seen - fv0, ce_seen - ce0, to_seen - to0); end
      tests_run++; if (motor_id !== 8'h00 || encoder0_position !== 24'sd0 || current !== 16'sd0) begin tests_failed++; $display("FAIL midrst_fields: got %0h/%0h/%0h want 0/0/0", motor_id, encoder0_position, current); end
      tests_run++; if (frames_ok !== 32'd0 || frames_bad !== 32'd0) begin tests_failed++; $display("FAIL midrst_cnt: got %0d/%0d want 0/0", frames_ok, frames_bad); end
      send_magic();
      send_payload(24);
      @(negedge clk);
      exp_ok++;
      tests_run++; if (frame_valid !== 1'b1 || motor_id !== 8'h41 || current !== -16'sd2) begin tests_failed++; $display("FAIL midrst_recover: got %0b/%0h/%0d want 1/41/-2", frame_valid, motor_id, current); end
      @(negedge clk);
      tests_run++; if (frames_ok !== (STATS ? 32'(exp_ok) : 32'd0)) begin tests_failed++; $display("FAIL midrst_frames_ok: got %0d want %0d", frames_ok, STATS ? exp_ok : 0); end
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_crc_error();
      test_garbage_sync();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
